// File: rtl/tiny45_mem_ctrl.sv
// rtl/tiny45_mem_ctrl.sv - QPI RAM data-side memory controller for tiny45_core
// One QSPI transaction per load/store; load data is replayed nibble-serially in the core's counter window.
module tiny45_mem_ctrl #(
  parameter int         ADDR_BITS  = 24,
  parameter int         READ_DUMMY = 6,
  parameter logic [7:0] CMD_READ   = 8'hEB,
  parameter logic [7:0] CMD_WRITE  = 8'h38
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  counter,
  input  logic        address_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [27:0] addr_in,
  input  logic [3:0]  store_data,
  output logic [3:0]  load_data,
  output logic        load_data_ready,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic [3:0]  spi_data_out,
  output logic [3:0]  spi_data_oe,
  input  logic [3:0]  spi_data_in
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ALIGN, RETURN} state_t;

  state_t               state, ns;
  logic                 phase;
  logic [5:0]           cnt, ncnt, len;
  logic [ADDR_BITS-1:0] addr, addr_sh;
  logic                 is_rd;
  logic [2:0]           nbytes;
  logic [31:0]          sr, wbuf, rbuf, rbuf_nx;
  logic [2:0]           rcnt, rnext;
  logic [3:0]           nib;
  logic [4:0]           widx, ridx;
  logic                 unused_bits;

  assign unused_bits = ^{mem_op[2], addr_in};

  // Where the bus goes after the current SPI clock, and the nibble it drives there.
  always_comb begin
    case (state)
      ADDR:    len = 6'(ADDR_BITS / 4);
      DUMMY:   len = 6'(READ_DUMMY);
      DATA:    len = {2'b00, nbytes, 1'b0};
      default: len = 6'd2;
    endcase
    ns   = state;
    ncnt = cnt + 6'd1;
    if (cnt == len - 6'd1) begin
      ncnt = '0;
      case (state)
        CMD:     ns = ADDR;
        ADDR:    ns = (is_rd && READ_DUMMY > 0) ? DUMMY : DATA;
        DUMMY:   ns = DATA;
        DATA:    ns = is_rd ? ALIGN : IDLE;
        default: ns = state;
      endcase
    end
  end

  always_comb begin
    addr_sh = addr >> (4 * (ADDR_BITS / 4 - 1 - int'(ncnt)));
    // Bytes ascend, high nibble of each byte first on the wire.
    widx    = {ncnt[2:1], ~ncnt[0], 2'b00};
    ridx    = {cnt[2:1], ~cnt[0], 2'b00};
    rnext   = rcnt + 3'd1;
    rbuf_nx = rbuf;
    rbuf_nx[ridx +: 4] = spi_data_in;
    case (ns)
      CMD:     nib = is_rd ? (ncnt[0] ? CMD_READ[3:0] : CMD_READ[7:4])
                           : (ncnt[0] ? CMD_WRITE[3:0] : CMD_WRITE[7:4]);
      ADDR:    nib = addr_sh[3:0];
      DATA:    nib = is_rd ? 4'h0 : wbuf[widx +: 4];
      default: nib = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      phase           <= 1'b0;
      cnt             <= '0;
      addr            <= '0;
      is_rd           <= 1'b0;
      nbytes          <= 3'd1;
      sr              <= '0;
      wbuf            <= '0;
      rbuf            <= '0;
      rcnt            <= '0;
      spi_cs_n        <= 1'b1;
      spi_clk         <= 1'b0;
      spi_data_oe     <= 4'h0;
      spi_data_out    <= 4'h0;
      load_data       <= 4'h0;
      load_data_ready <= 1'b0;
      busy            <= 1'b0;
    end else begin
      if (is_store)
        sr <= {store_data, sr[31:4]};
      // wbuf is frozen while busy so a stray request cannot corrupt an in-flight write.
      if (state == IDLE && address_ready && is_store)
        wbuf <= {store_data, sr[31:4]};
      case (state)
        IDLE: begin
          if (address_ready && (is_load ^ is_store)) begin
            addr         <= addr_in[ADDR_BITS-1:0];
            is_rd        <= is_load;
            nbytes       <= mem_op[1] ? 3'd4 : (mem_op[0] ? 3'd2 : 3'd1);
            rbuf         <= '0;
            cnt          <= '0;
            phase        <= 1'b0;
            state        <= CMD;
            busy         <= 1'b1;
            spi_cs_n     <= 1'b0;
            spi_clk      <= 1'b0;
            spi_data_oe  <= 4'hF;
            spi_data_out <= is_load ? CMD_READ[7:4] : CMD_WRITE[7:4];
          end
        end
        CMD, ADDR, DUMMY, DATA: begin
          if (!phase) begin
            phase   <= 1'b1;
            spi_clk <= 1'b1;
          end else begin
            phase   <= 1'b0;
            spi_clk <= 1'b0;
            cnt     <= ncnt;
            if (state == DATA && is_rd)
              rbuf <= rbuf_nx;
            if (ns == IDLE || ns == ALIGN) begin
              spi_cs_n     <= 1'b1;
              spi_data_oe  <= 4'h0;
              spi_data_out <= 4'h0;
            end else begin
              spi_data_out <= nib;
              spi_data_oe  <= (ns == DUMMY || (ns == DATA && is_rd)) ? 4'h0 : 4'hF;
            end
            if (ns == IDLE)
              busy <= 1'b0;
            // Already at the window edge: skip ALIGN rather than waiting a full window.
            if (ns == ALIGN && counter == 3'd7) begin
              state           <= RETURN;
              rcnt            <= '0;
              load_data       <= rbuf_nx[3:0];
              load_data_ready <= 1'b1;
            end else begin
              state <= ns;
            end
          end
        end
        ALIGN: begin
          if (counter == 3'd7) begin
            state           <= RETURN;
            rcnt            <= '0;
            load_data       <= rbuf[3:0];
            load_data_ready <= 1'b1;
          end
        end
        RETURN: begin
          if (rcnt == 3'd7) begin
            state           <= IDLE;
            load_data       <= 4'h0;
            load_data_ready <= 1'b0;
            busy            <= 1'b0;
          end else begin
            rcnt      <= rnext;
            load_data <= rbuf[{rnext, 2'b00} +: 4];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny45_mem_ctrl.sv
// tb/tb_tiny45_mem_ctrl.sv - scoreboard bench for tiny45_mem_ctrl
// Two instances (READ_DUMMY 6 and 4) share core inputs; one is monitored at a time.
module tb_tiny45_mem_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  counter = 3'd0;
  logic        address_ready = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  mem_op = 3'd0;
  logic [27:0] addr_in = 28'd0;
  logic [3:0]  store_data = 4'd0;

  logic [7:0]  ram [0:255];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [9:0]  exp_bus [$];   // {dont_care_data, cs_n, oe[3:0], nibble}
  logic [6:0]  exp_load [$];  // {counter, nibble}
  logic        mon_en = 1'b0;
  int          sel = 0;
  logic [9:0]  eb;
  logic [6:0]  el;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 counter = counter + 3'd1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DUMMY = (g == 0) ? 6 : 4;
    logic [3:0] load_data, spi_data_out, spi_data_oe;
    logic       load_data_ready, busy, spi_cs_n, spi_clk;
    logic [3:0] spi_data_in = 4'h0;
    int         k = 0;
    int         d;
    logic [31:0] hdr = 32'h0;
    logic [7:0]  b;

    tiny45_mem_ctrl #(
      .ADDR_BITS(24), .READ_DUMMY(DUMMY), .CMD_READ(8'hEB), .CMD_WRITE(8'h38)
    ) dut (
      .clk(clk), .rstn(rstn), .counter(counter), .address_ready(address_ready),
      .is_load(is_load), .is_store(is_store), .mem_op(mem_op), .addr_in(addr_in),
      .store_data(store_data), .load_data(load_data), .load_data_ready(load_data_ready),
      .busy(busy), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_data_out(spi_data_out),
      .spi_data_oe(spi_data_oe), .spi_data_in(spi_data_in)
    );

    // QPI RAM model: decodes command/address, drives read data during the high half of spi_clk.
    always @(negedge clk) begin
      if (spi_cs_n) begin
        k = 0;
      end else if (spi_clk) begin
        if (k < 8) begin
          hdr = {hdr[27:0], spi_data_out};
        end else if (hdr[31:24] == 8'hEB && k >= 8 + DUMMY) begin
          d = k - 8 - DUMMY;
          b = ram[8'(hdr[7:0] + 8'(d / 2))];
          spi_data_in = (d % 2 == 0) ? b[7:4] : b[3:0];
        end
        k++;
      end
    end
  end

  logic       m_csn, m_sclk, m_rdy, m_busy;
  logic [3:0] m_oe, m_sdo, m_ld;
  always_comb begin
    if (sel == 0) begin
      m_csn = g_dut[0].spi_cs_n; m_sclk = g_dut[0].spi_clk; m_rdy = g_dut[0].load_data_ready;
      m_busy = g_dut[0].busy; m_oe = g_dut[0].spi_data_oe; m_sdo = g_dut[0].spi_data_out;
      m_ld = g_dut[0].load_data;
    end else begin
      m_csn = g_dut[1].spi_cs_n; m_sclk = g_dut[1].spi_clk; m_rdy = g_dut[1].load_data_ready;
      m_busy = g_dut[1].busy; m_oe = g_dut[1].spi_data_oe; m_sdo = g_dut[1].spi_data_out;
      m_ld = g_dut[1].load_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rstn) begin
      if (m_sclk) begin
        if (exp_bus.size() == 0) begin
          check("bus_extra", {23'd0, m_csn, m_oe, m_sdo}, 32'hFFFF_FFFF);
        end else begin
          eb = exp_bus.pop_front();
          check("bus", {m_csn, m_oe, eb[9] ? 4'h0 : m_sdo}, {eb[8], eb[7:4], eb[9] ? 4'h0 : eb[3:0]});
        end
      end
      if (m_rdy) begin
        if (exp_load.size() == 0) begin
          check("load_extra", {counter, m_ld}, 32'hFFFF_FFFF);
        end else begin
          el = exp_load.pop_front();
          check("load", {counter, m_ld}, el);
        end
      end
    end
  end

  task automatic push_req(input bit ld, input logic [23:0] a, input int nb,
                          input logic [31:0] wd, input int dummy);
    logic [7:0]  cmd;
    logic [31:0] r;
    cmd = ld ? 8'hEB : 8'h38;
    exp_bus.push_back({2'b00, 4'hF, cmd[7:4]});
    exp_bus.push_back({2'b00, 4'hF, cmd[3:0]});
    for (int i = 5; i >= 0; i--) exp_bus.push_back({2'b00, 4'hF, a[4*i +: 4]});
    if (ld) begin
      for (int i = 0; i < dummy + 2 * nb; i++) exp_bus.push_back({2'b10, 4'h0, 4'h0});
      r = 32'h0;
      for (int i = 0; i < nb; i++) r[8*i +: 8] = ram[8'(a[7:0] + 8'(i))];
      for (int c = 0; c < 8; c++) exp_load.push_back({3'(c), r[4*c +: 4]});
    end else begin
      for (int i = 0; i < nb; i++) begin
        exp_bus.push_back({2'b00, 4'hF, wd[8*i+4 +: 4]});
        exp_bus.push_back({2'b00, 4'hF, wd[8*i +: 4]});
      end
    end
  endtask

  task automatic issue(input bit ld, input logic [2:0] op, input logic [27:0] a, input logic [31:0] wd);
    do @(negedge clk); while (counter != 3'd0);
    for (int c = 0; c < 8; c++) begin
      is_load = ld; is_store = !ld; mem_op = op; addr_in = a;
      store_data = wd[4*c +: 4]; address_ready = (c == 7);
      @(negedge clk);
    end
    is_load = 1'b0; is_store = 1'b0; address_ready = 1'b0; store_data = 4'h0;
  endtask

  task automatic wait_idle(output int nbusy);
    nbusy = 0;
    while (m_busy && nbusy < 300) begin
      nbusy++;
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, m_busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("bus_left", exp_bus.size(), 32'd0);
    check("load_left", exp_load.size(), 32'd0);
  endtask

  int nb, rc;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    ram[8'h10] = 8'h21; ram[8'h11] = 8'h43; ram[8'h12] = 8'h65; ram[8'h13] = 8'h87;
    ram[8'h03] = 8'hFE; ram[8'h04] = 8'hFF;

    repeat (4) @(negedge clk);
    check("rst_csn", {31'd0, m_csn}, 32'd1);
    check("rst_sclk", {31'd0, m_sclk}, 32'd0);
    check("rst_oe", {28'd0, m_oe}, 32'd0);
    check("rst_sdo", {28'd0, m_sdo}, 32'd0);
    check("rst_ld", {27'd0, m_rdy, m_ld}, 32'd0);
    check("rst_busy", {30'd0, g_dut[1].busy, m_busy}, 32'd0);
    rstn = 1'b1;
    mon_en = 1'b1;

    push_req(1, 24'h000010, 4, 32'h0, 6);
    issue(1, 3'b010, 28'h0000010, 32'h0);
    wait_idle(nb);
    check("lw_busy", nb, 32'd56);

    push_req(0, 24'h123456, 1, 32'h000000A5, 6);
    issue(0, 3'b000, 28'h0123456, 32'h000000A5);
    wait_idle(nb);
    check("sb_busy", nb, 32'd20);
    check("sb_csn", {31'd0, m_csn}, 32'd1);

    push_req(1, 24'h000003, 2, 32'h0, 6);
    issue(1, 3'b001, 28'h0000003, 32'h0);
    wait_idle(nb);

    push_req(1, 24'h000011, 1, 32'h0, 6);
    issue(1, 3'b100, 28'h0000011, 32'h0);
    wait_idle(nb);

    mon_en = 1'b0;
    issue(1, 3'b010, 28'h0000010, 32'h0);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_csn", {30'd0, g_dut[1].spi_cs_n, m_csn}, 32'd3);
    check("abort_busy", {30'd0, g_dut[1].busy, m_busy}, 32'd0);
    check("abort_sclk", {31'd0, m_sclk}, 32'd0);
    rstn = 1'b1;
    rc = 0;
    for (int i = 0; i < 80; i++) begin
      rc = rc + int'(g_dut[0].load_data_ready) + int'(g_dut[1].load_data_ready) + int'(m_busy);
      @(negedge clk);
    end
    check("abort_no_ready", rc, 32'd0);
    mon_en = 1'b1;
    push_req(0, 24'h000020, 4, 32'hDEADBEEF, 6);
    issue(0, 3'b010, 28'h0000020, 32'hDEADBEEF);
    wait_idle(nb);
    check("sw_busy", nb, 32'd32);

    push_req(0, 24'h000040, 4, 32'h11223344, 6);
    issue(0, 3'b010, 28'h0000040, 32'h11223344);
    repeat (20) @(negedge clk);
    address_ready = 1'b1; is_load = 1'b1; mem_op = 3'b010; addr_in = 28'h0000099;
    @(negedge clk);
    address_ready = 1'b0; is_load = 1'b0;
    wait_idle(nb);
    rc = 0;
    for (int i = 0; i < 60; i++) begin
      rc = rc + int'(m_busy) + int'(!m_csn);
      @(negedge clk);
    end
    check("ignored_req", rc, 32'd0);

    sel = 1;
    push_req(1, 24'h000010, 4, 32'h0, 4);
    issue(1, 3'b010, 28'h0000010, 32'h0);
    wait_idle(nb);
    check("lw_dummy4_busy", nb, 32'd48);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
